mem_port_arbiter: RTL and testbench

- Shares one 256-bit line-granular memory port between the I-cache miss port (read-only) and the D-cache miss/writeback port (read/write) of aquila_top.
- Sits between the core's M_IMEM_*/M_DMEM_* interfaces and a single-ported memory controller or mock RAM.
- Registers requests, arbitrates round-robin, sequences one downstream transaction at a time, and routes the response back.
- Includes a watchdog that aborts hung transactions.

---
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between an I-cache read port and a D-cache read/write port.
// One downstream transaction in flight at a time; a watchdog aborts transactions whose memory never answers.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  I_strobe_i,
  input  logic [ADDR_WIDTH-1:0] I_addr_i,
  output logic                  I_done_o,
  output logic [LINE_WIDTH-1:0] I_data_o,
  input  logic                  D_strobe_i,
  input  logic [ADDR_WIDTH-1:0] D_addr_i,
  input  logic                  D_rw_i,
  input  logic [LINE_WIDTH-1:0] D_data_i,
  output logic                  D_done_o,
  output logic [LINE_WIDTH-1:0] D_data_o,
  output logic                  M_strobe_o,
  output logic [ADDR_WIDTH-1:0] M_addr_o,
  output logic                  M_rw_o,
  output logic [LINE_WIDTH-1:0] M_data_o,
  input  logic                  M_done_i,
  input  logic [LINE_WIDTH-1:0] M_data_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;
  localparam bit   WD_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] WD_LAST = WD_EN ? CNT_WIDTH'(TIMEOUT_CYCLES - 1) : '0;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    last_q, last_d;
  logic                    pend_i_q, pend_i_d;
  logic                    pend_d_q, pend_d_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   i_addr_q, i_addr_d;
  logic [ADDR_WIDTH-1:0]   d_addr_q, d_addr_d;
  logic                    d_rw_q, d_rw_d;
  logic [LINE_WIDTH-1:0]   d_wdata_q, d_wdata_d;
  logic [LINE_WIDTH-1:0]   i_rdata_q, i_rdata_d;
  logic [LINE_WIDTH-1:0]   d_rdata_q, d_rdata_d;

  logic active, wd_hit, i_in_svc, d_in_svc;

  assign active   = (state_q == ISSUE) || (state_q == WAIT);
  assign i_in_svc = (state_q != IDLE) && (grant_q == GNT_I);
  assign d_in_svc = (state_q != IDLE) && (grant_q == GNT_D);
  assign wd_hit   = WD_EN && (state_q == WAIT) && !M_done_i && (cnt_q == WD_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    pend_i_d  = pend_i_q;
    pend_d_d  = pend_d_q;
    cnt_d     = cnt_q;
    i_addr_d  = i_addr_q;
    d_addr_d  = d_addr_q;
    d_rw_d    = d_rw_q;
    d_wdata_d = d_wdata_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    // A port that is waiting or being served keeps its latched request untouched.
    if (I_strobe_i && !pend_i_q && !i_in_svc) begin
      pend_i_d = 1'b1;
      i_addr_d = I_addr_i;
    end
    if (D_strobe_i && !pend_d_q && !d_in_svc) begin
      pend_d_d  = 1'b1;
      d_addr_d  = D_addr_i;
      d_rw_d    = D_rw_i;
      d_wdata_d = D_data_i;
    end

    case (state_q)
      IDLE: begin
        if (pend_i_q || pend_d_q) begin
          if (pend_i_q && pend_d_q) grant_d = ~last_q;
          else                      grant_d = pend_d_q ? GNT_D : GNT_I;
          last_d  = grant_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (grant_q == GNT_I) pend_i_d = 1'b0;
        else                  pend_d_d = 1'b0;
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        if (M_done_i) begin
          if (grant_q == GNT_I)  i_rdata_d = M_data_i;
          else if (!d_rw_q)      d_rdata_d = M_data_i;
          state_d = RESP;
        end else if (wd_hit) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= GNT_I;
      last_q    <= GNT_D;
      pend_i_q  <= 1'b0;
      pend_d_q  <= 1'b0;
      cnt_q     <= '0;
      i_addr_q  <= '0;
      d_addr_q  <= '0;
      d_rw_q    <= 1'b0;
      d_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      pend_i_q  <= pend_i_d;
      pend_d_q  <= pend_d_d;
      cnt_q     <= cnt_d;
      i_addr_q  <= i_addr_d;
      d_addr_q  <= d_addr_d;
      d_rw_q    <= d_rw_d;
      d_wdata_q <= d_wdata_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  // Downstream fields are driven only while a transaction is outstanding.
  assign M_strobe_o = (state_q == ISSUE);
  assign M_addr_o   = !active ? '0 : (grant_q == GNT_D) ? d_addr_q : i_addr_q;
  assign M_rw_o     = active && (grant_q == GNT_D) && d_rw_q;
  assign M_data_o   = (active && (grant_q == GNT_D)) ? d_wdata_q : '0;
  assign I_done_o   = (state_q == RESP) && (grant_q == GNT_I);
  assign D_done_o   = (state_q == RESP) && (grant_q == GNT_D);
  assign I_data_o   = i_rdata_q;
  assign D_data_o   = d_rdata_q;
  assign busy_o     = (state_q != IDLE);
  assign timeout_o  = wd_hit;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic against a
// transaction-level model (golden memory, alternating-winner arbitration, expected latencies).
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int LW = 256;
  localparam int TO = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_i, I_strobe_i, D_strobe_i, D_rw_i;
  logic          M_done_i = 1'b0;
  logic [AW-1:0] I_addr_i, D_addr_i;
  logic [LW-1:0] D_data_i;
  logic [LW-1:0] M_data_i = '0;
  logic          I_done_o, D_done_o, M_strobe_o, M_rw_o, busy_o, timeout_o;
  logic [LW-1:0] I_data_o, D_data_o, M_data_o;
  logic [AW-1:0] M_addr_o;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TO), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .I_strobe_i(I_strobe_i), .I_addr_i(I_addr_i), .I_done_o(I_done_o), .I_data_o(I_data_o),
    .D_strobe_i(D_strobe_i), .D_addr_i(D_addr_i), .D_rw_i(D_rw_i), .D_data_i(D_data_i),
    .D_done_o(D_done_o), .D_data_o(D_data_o),
    .M_strobe_o(M_strobe_o), .M_addr_o(M_addr_o), .M_rw_o(M_rw_o), .M_data_o(M_data_o),
    .M_done_i(M_done_i), .M_data_i(M_data_i),
    .busy_o(busy_o), .timeout_o(timeout_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Mock RAM: answers mem_lat cycles after the strobe cycle.
  logic [LW-1:0] ram [logic [AW-1:0]];
  int            mem_lat = 1;
  int            mem_left = 0;
  logic [AW-1:0] mem_a = '0;
  always @(posedge clk) begin
    #1;
    M_done_i = 1'b0;
    if (mem_left > 0) begin
      mem_left--;
      if (mem_left == 0) begin
        M_done_i = 1'b1;
        M_data_i = ram.exists(mem_a) ? ram[mem_a] : '0;
      end
    end
    if (M_strobe_o) begin
      mem_a = M_addr_o;
      if (M_rw_o) ram[M_addr_o] = M_data_o;
      mem_left = mem_lat;
    end
  end

  // Event log of what the DUT did, sampled mid-cycle.
  int            n_ms = 0, n_id = 0, n_dd = 0, n_to = 0, hold_err = 0;
  int            id_cyc = 0, dd_cyc = 0, to_cyc = 0;
  logic [AW-1:0] ms_addr [$];
  logic          ms_rw   [$];
  logic [LW-1:0] ms_data [$];
  int            ms_cyc  [$];
  logic          in_txn = 1'b0;
  logic [AW-1:0] t_addr;
  logic          t_rw;
  logic [LW-1:0] t_data;
  always @(negedge clk) begin
    if (rst_i) begin
      in_txn = 1'b0;
    end else begin
      if (M_strobe_o) begin
        n_ms++;
        ms_addr.push_back(M_addr_o); ms_rw.push_back(M_rw_o);
        ms_data.push_back(M_data_o); ms_cyc.push_back(cyc);
        in_txn = 1'b1; t_addr = M_addr_o; t_rw = M_rw_o; t_data = M_data_o;
      end else if (in_txn && !I_done_o && !D_done_o &&
                   (M_addr_o !== t_addr || M_rw_o !== t_rw || M_data_o !== t_data)) begin
        hold_err++;
      end
      if (I_done_o)  begin n_id++; id_cyc = cyc; in_txn = 1'b0; end
      if (D_done_o)  begin n_dd++; dd_cyc = cyc; in_txn = 1'b0; end
      if (timeout_o) begin n_to++; to_cyc = cyc; end
    end
  end

  int n_assert = 0;
  int n_fail = 0;

  task automatic chk256(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue(input bit di, input logic [AW-1:0] ia, input bit dd, input logic [AW-1:0] da,
                       input bit drw, input logic [LW-1:0] dw);
    I_strobe_i = di;
    if (di) I_addr_i = ia;
    D_strobe_i = dd;
    if (dd) begin
      D_addr_i = da; D_rw_i = drw; D_data_i = dw;
    end
    cycles(1);
    I_strobe_i = 1'b0;
    D_strobe_i = 1'b0;
  endtask

  task automatic wait_dones(input int target, input string tag);
    int k = 0;
    while ((n_id + n_dd) < target && k < 100) begin
      cycles(1);
      k++;
    end
    chki(tag, int'((n_id + n_dd) >= target), 1);
  endtask

  // Transaction-level reference: golden memory and the identity of the last winner.
  logic [LW-1:0] gold [logic [AW-1:0]];
  bit            model_last_d = 1'b1;
  logic [LW-1:0] exp_i = '0, exp_d = '0;

  function automatic logic [LW-1:0] grd(input logic [AW-1:0] a);
    return gold.exists(a) ? gold[a] : '0;
  endfunction

  function automatic logic [LW-1:0] rline();
    logic [LW-1:0] l;
    for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom();
    return l;
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [LW-1:0] l);
    ram[a] = l;
    gold[a] = l;
  endtask

  task automatic run_txn(input bit di, input logic [AW-1:0] ia, input bit dd, input logic [AW-1:0] da,
                         input bit drw, input logic [LW-1:0] dw, input int lat);
    int b_ms, b_dn, nexp;
    bit seq_d [2];
    b_ms = n_ms;
    b_dn = n_id + n_dd;
    nexp = int'(di) + int'(dd);
    if (di && dd) begin
      seq_d[0] = !model_last_d;
      seq_d[1] = model_last_d;
    end else begin
      seq_d[0] = dd;
      seq_d[1] = dd;
    end
    mem_lat = lat;
    issue(di, ia, dd, da, drw, dw);
    wait_dones(b_dn + nexp, "txn_done");
    chki("txn_count", n_ms - b_ms, nexp);
    for (int j = 0; j < nexp; j++) begin
      if (ms_addr.size() > b_ms + j) begin
        chki("txn_addr", int'(ms_addr[b_ms + j]), int'(seq_d[j] ? da : ia));
        chki("txn_rw", int'(ms_rw[b_ms + j]), int'(seq_d[j] && drw));
        if (seq_d[j] && drw) chk256("txn_wdata", ms_data[b_ms + j], dw);
      end
      if (!seq_d[j])  exp_i = grd(ia);
      else if (drw)   gold[da] = dw;
      else            exp_d = grd(da);
      model_last_d = seq_d[j];
    end
    chk256("txn_idata", I_data_o, exp_i);
    chk256("txn_ddata", D_data_o, exp_d);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL sim_timeout observed=still_running expected=finished");
    $fatal(1);
  end

  initial begin
    int            t0, b, bid, bdd, sel, lat;
    logic [AW-1:0] ra, rb;
    logic          rrw;
    logic [LW-1:0] rd, a5, deadbeef, saved;

    rst_i = 1'b1; I_strobe_i = 1'b0; D_strobe_i = 1'b0; D_rw_i = 1'b0;
    I_addr_i = '0; D_addr_i = '0; D_data_i = '0;
    a5 = {32{8'hA5}};
    deadbeef = {8{32'hDEADBEEF}};
    preload(32'h1000, a5);
    foreach (ram[a]) gold[a] = ram[a];
    preload(32'h100, rline()); preload(32'h200, rline());
    preload(32'h140, rline()); preload(32'h240, rline());
    preload(32'h300, rline()); preload(32'h500, rline()); preload(32'h600, rline());
    for (int k = 0; k < 4; k++) preload(32'h400 + 32'(k) * 32'h20, rline());

    cycles(3);
    rst_i = 1'b0;
    chki("rst_busy", int'(busy_o), 0);
    chki("rst_mstrobe", int'(M_strobe_o), 0);
    chki("rst_done", int'({I_done_o, D_done_o, timeout_o, M_rw_o}), 0);
    chki("rst_maddr", int'(M_addr_o), 0);
    chk256("rst_idata", I_data_o, '0);
    chk256("rst_ddata", D_data_o, '0);
    chk256("rst_mdata", M_data_o, '0);

    // Tie right after reset: I wins.
    b = n_ms;
    run_txn(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, '0, 2);
    if (ms_addr.size() > b + 1) chki("tie1_first_is_i", int'(ms_addr[b]), 32'h100);

    // Single I read with exact latencies.
    b = n_ms; bid = n_id; bdd = n_dd; mem_lat = 3; t0 = cyc;
    issue(1'b1, 32'h1000, 1'b0, '0, 1'b0, '0);
    wait_dones(bid + bdd + 1, "single_done");
    chki("single_strobes", n_ms - b, 1);
    if (ms_addr.size() > b) begin
      chki("single_maddr", int'(ms_addr[b]), 32'h1000);
      chki("single_mrw", int'(ms_rw[b]), 0);
      chki("single_issue_cyc", ms_cyc[b], t0 + 2);
    end
    chki("single_done_cyc", id_cyc, t0 + 6);
    chk256("single_idata", I_data_o, a5);
    cycles(3);
    chki("single_one_pulse", n_id - bid, 1);
    chki("single_no_ddone", n_dd - bdd, 0);
    exp_i = a5; model_last_d = 1'b0;

    // Tie after an I grant: D wins.
    b = n_ms;
    run_txn(1'b1, 32'h140, 1'b1, 32'h240, 1'b0, '0, 1);
    if (ms_addr.size() > b + 1) chki("tie2_first_is_d", int'(ms_addr[b]), 32'h240);

    // D write then read back.
    saved = D_data_o; b = n_ms;
    run_txn(1'b0, '0, 1'b1, 32'h300, 1'b1, deadbeef, 2);
    if (ms_data.size() > b) chk256("wr_mdata", ms_data[b], deadbeef);
    chk256("wr_ddata_unchanged", D_data_o, saved);
    run_txn(1'b0, '0, 1'b1, 32'h300, 1'b0, '0, 2);
    chk256("rd_back", D_data_o, deadbeef);

    // D request (and an ignored duplicate I strobe) while I is in WAIT.
    b = n_ms; bid = n_id; mem_lat = 5; t0 = cyc;
    issue(1'b1, 32'h500, 1'b0, '0, 1'b0, '0);
    cycles(1);
    issue(1'b1, 32'hBAD0, 1'b1, 32'h600, 1'b0, '0);
    wait_dones(n_id + n_dd + 2 - ((n_id > bid) ? 1 : 0), "svc_done");
    chki("svc_strobes", n_ms - b, 2);
    chki("svc_i_done_cyc", id_cyc, t0 + 8);
    if (ms_addr.size() > b + 1) begin
      chki("svc_first", int'(ms_addr[b]), 32'h500);
      chki("svc_second", int'(ms_addr[b + 1]), 32'h600);
      chki("svc_gap", ms_cyc[b + 1], id_cyc + 2);
    end
    chki("svc_i_once", n_id - bid, 1);
    exp_i = grd(32'h500); exp_d = grd(32'h600); model_last_d = 1'b1;
    chk256("svc_idata", I_data_o, exp_i);
    chk256("svc_ddata", D_data_o, exp_d);

    // Random traffic against the reference model.
    for (int it = 0; it < 24; it++) begin
      sel = int'($urandom_range(0, 2));
      lat = int'($urandom_range(1, 6));
      ra  = 32'h400 + 32'($urandom_range(0, 3)) * 32'h20;
      rb  = 32'h400 + 32'($urandom_range(0, 3)) * 32'h20;
      rrw = 1'($urandom_range(0, 1));
      rd  = rline();
      run_txn(sel != 1, ra, sel != 0, rb, rrw, rd, lat);
    end

    // Watchdog abort: memory answers only after the abort.
    saved = I_data_o; bid = n_id; bdd = n_dd; b = n_to; mem_lat = 12; t0 = cyc;
    issue(1'b1, 32'h1000, 1'b0, '0, 1'b0, '0);
    wait_dones(bid + bdd + 1, "to_done");
    chki("to_pulses", n_to - b, 1);
    chki("to_cyc", to_cyc, t0 + 10);
    chki("to_done_cyc", id_cyc, t0 + 11);
    chk256("to_idata_kept", I_data_o, saved);
    cycles(15);
    chki("to_late_ignored", n_id + n_dd - bid - bdd, 1);
    chki("to_single_pulse", n_to - b, 1);
    model_last_d = 1'b0;
    run_txn(1'b1, 32'h1000, 1'b0, '0, 1'b0, '0, 2);
    chk256("to_recover", I_data_o, a5);

    // Reset in the middle of a D read's WAIT.
    bid = n_id; bdd = n_dd; mem_lat = 6;
    issue(1'b0, '0, 1'b1, 32'h200, 1'b0, '0);
    cycles(3);
    rst_i = 1'b1;
    cycles(1);
    rst_i = 1'b0;
    chki("mrst_busy", int'(busy_o), 0);
    chki("mrst_ctl", int'({M_strobe_o, I_done_o, D_done_o, timeout_o, M_rw_o}), 0);
    chki("mrst_maddr", int'(M_addr_o), 0);
    chk256("mrst_idata", I_data_o, '0);
    chk256("mrst_ddata", D_data_o, '0);
    cycles(10);
    chki("mrst_stale_ignored", n_id + n_dd - bid - bdd, 0);
    chki("mrst_idle", int'(busy_o), 0);
    model_last_d = 1'b1; exp_i = '0; exp_d = '0;
    b = n_ms;
    run_txn(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, '0, 1);
    if (ms_addr.size() > b + 1) chki("mrst_tie_first_is_i", int'(ms_addr[b]), 32'h100);

    chki("m_fields_held", hold_err, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
